// File: rtl/audio_calib_ctrl.sv
// Multi-channel DC-offset calibration: settle, average 2^LOG2N frames per masked
// channel, latch offsets, and stream offset-corrected saturated samples.

module audio_calib_lane #(
  parameter int DW    = 16,
  parameter int LOG2N = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] sample,
  input  logic                 vld,
  input  logic                 clr,
  input  logic                 acc_en,
  input  logic                 ld,
  output logic signed [DW-1:0] offset,
  output logic                 done,
  output logic        [DW-1:0] corr
);
  localparam int AW = DW + LOG2N;

  logic signed [AW-1:0] acc;
  logic        [DW:0]   diff;
  logic        [DW-1:0] sat;

  assign diff = {sample[DW-1], sample} - {offset[DW-1], offset};

  // Top two bits disagree only when the difference left the DW-bit range.
  always_comb begin
    sat = diff[DW-1:0];
    if (diff[DW] != diff[DW-1])
      sat = diff[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      offset <= '0;
      done   <= 1'b0;
      corr   <= '0;
    end else begin
      if (clr) begin
        acc  <= '0;
        done <= 1'b0;
      end else if (acc_en) begin
        acc <= acc + AW'(sample);
      end
      if (ld) begin
        offset <= DW'(acc >>> LOG2N);
        done   <= 1'b1;
      end
      if (vld) corr <= sat;
    end
  end
endmodule

module audio_calib_ctrl #(
  parameter int CH     = 4,
  parameter int DW     = 16,
  parameter int LOG2N  = 8,
  parameter int SETTLE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CH*DW-1:0] sample_i,
  input  logic             sample_vld,
  input  logic             calib_req,
  input  logic [CH-1:0]    ch_mask,
  output logic             busy,
  output logic [CH-1:0]    calib_done,
  output logic [CH*DW-1:0] offset_o,
  output logic [CH*DW-1:0] corr_o,
  output logic             corr_vld
);
  localparam int NFR  = 1 << LOG2N;
  localparam int CMAX = (SETTLE > NFR) ? SETTLE : NFR;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] SET_LAST = CW'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [CW-1:0] ACC_LAST = CW'(NFR - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_ACC, S_DIV} state_t;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic [CH-1:0]           mask;
  logic                    accept;
  logic [CH-1:0]           clr, acc_en, ld;
  logic [CH-1:0][DW-1:0]   smp, off, corr;

  assign accept = (state == S_IDLE) && calib_req && (|ch_mask);
  assign clr    = accept ? ch_mask : '0;
  assign acc_en = (state == S_ACC && sample_vld) ? mask : '0;
  assign ld     = (state == S_DIV) ? mask : '0;

  assign smp      = sample_i;
  assign offset_o = off;
  assign corr_o   = corr;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      mask     <= '0;
      busy     <= 1'b0;
      corr_vld <= 1'b0;
    end else begin
      corr_vld <= sample_vld;
      case (state)
        S_IDLE: if (accept) begin
          mask  <= ch_mask;
          cnt   <= '0;
          busy  <= 1'b1;
          state <= (SETTLE == 0) ? S_ACC : S_SETTLE;
        end
        // The frame that completes settling is not accumulated.
        S_SETTLE: if (sample_vld) begin
          if (cnt == SET_LAST) begin
            cnt   <= '0;
            state <= S_ACC;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_ACC: if (sample_vld) begin
          if (cnt == ACC_LAST) begin
            cnt   <= '0;
            state <= S_DIV;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DIV: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_lane
    audio_calib_lane #(.DW(DW), .LOG2N(LOG2N)) u_lane (
      .clk    (clk),
      .rst    (rst_n),
      .sample (smp[c]),
      .vld    (sample_vld),
      .clr    (clr[c]),
      .acc_en (acc_en[c]),
      .ld     (ld[c]),
      .offset (off[c]),
      .done   (calib_done[c]),
      .corr   (corr[c])
    );
  end
endmodule

// File: tb/tb_audio_calib_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic, compared every
// cycle against a frame-counting reference model.

module tb_audio_calib_ctrl;
  localparam int CH = 2, DW = 16, LOG2N = 3, SETTLE = 2, NFR = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [CH*DW-1:0] sample_i = '0;
  logic             sample_vld = 1'b0, calib_req = 1'b0;
  logic [CH-1:0]    ch_mask = '0;
  logic             busy, corr_vld;
  logic [CH-1:0]    calib_done;
  logic [CH*DW-1:0] offset_o, corr_o;

  int errs = 0, checks = 0;
  bit mon_en = 0;
  int f0[10], f1[10];
  int sv0, sv1, sdone;

  always #5 clk = ~clk;

  audio_calib_ctrl #(.CH(CH), .DW(DW), .LOG2N(LOG2N), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst), .sample_i(sample_i), .sample_vld(sample_vld),
    .calib_req(calib_req), .ch_mask(ch_mask), .busy(busy), .calib_done(calib_done),
    .offset_o(offset_o), .corr_o(corr_o), .corr_vld(corr_vld)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sx(input logic [DW-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic int sat(input int d);
    if (d > 32767) return 32767;
    if (d < -32768) return -32768;
    return d;
  endfunction

  function automatic int fdiv(input int s);
    return (s >= 0) ? s / NFR : -((-s + NFR - 1) / NFR);
  endfunction

  function automatic int mean(input int ch);
    int s = 0;
    for (int i = SETTLE; i < SETTLE + NFR; i++) s += (ch == 0) ? f0[i] : f1[i];
    return fdiv(s);
  endfunction

  // Reference model: counts frames since acceptance, sums the post-settle ones.
  int m_off[CH], m_sum[CH], m_corr[CH];
  bit m_done[CH];
  bit m_busy, m_pend, m_cv;
  logic [CH-1:0] m_mask;
  int m_n;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CH; c++) begin
        m_off[c] = 0; m_sum[c] = 0; m_corr[c] = 0; m_done[c] = 0;
      end
      m_busy = 0; m_pend = 0; m_cv = 0; m_mask = '0; m_n = 0;
    end else begin
      m_cv = sample_vld;
      if (sample_vld)
        for (int c = 0; c < CH; c++) m_corr[c] = sat(sx(sample_i[c*DW +: DW]) - m_off[c]);
      if (!m_busy) begin
        if (calib_req && ch_mask != 0) begin
          m_busy = 1; m_mask = ch_mask; m_n = 0;
          for (int c = 0; c < CH; c++) begin
            m_sum[c] = 0;
            if (ch_mask[c]) m_done[c] = 0;
          end
        end
      end else if (m_pend) begin
        for (int c = 0; c < CH; c++)
          if (m_mask[c]) begin m_off[c] = fdiv(m_sum[c]); m_done[c] = 1; end
        m_busy = 0; m_pend = 0;
      end else if (sample_vld) begin
        m_n++;
        if (m_n > SETTLE)
          for (int c = 0; c < CH; c++) m_sum[c] += sx(sample_i[c*DW +: DW]);
        if (m_n == SETTLE + NFR) m_pend = 1;
      end
    end
  end

  always @(negedge clk) if (mon_en) begin
    chk("busy", busy, int'(m_busy));
    chk("corr_vld", corr_vld, int'(m_cv));
    for (int c = 0; c < CH; c++) begin
      chk($sformatf("done%0d", c), calib_done[c], int'(m_done[c]));
      chk($sformatf("off%0d", c), sx(offset_o[c*DW +: DW]), m_off[c]);
      if (m_cv) chk($sformatf("corr%0d", c), sx(corr_o[c*DW +: DW]), m_corr[c]);
    end
  end

  // Inputs are applied just after an edge and take effect at the next edge.
  task automatic tick(input bit v, input int a, input int b, input bit r, input logic [1:0] m);
    sample_vld = v;
    sample_i   = {DW'(b), DW'(a)};
    calib_req  = r;
    ch_mask    = m;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(0, 0, 0, 0, ch_mask);
  endtask

  // Ten frames from f0/f1; returns in the DIV cycle. req_at pulses calib_req on that frame.
  task automatic frames(input bit b2b, input int req_at);
    for (int i = 0; i < 10; i++) begin
      if (!b2b) repeat ($urandom_range(0, 2)) tick(0, 0, 0, 0, ch_mask);
      tick(1, f0[i], f1[i], i == req_at, ch_mask);
    end
    sample_vld = 0; calib_req = 0;
  endtask

  function automatic int rnd();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic fill(input int a, input int b, input bit ra, input bit rb);
    for (int i = 0; i < 10; i++) begin
      f0[i] = ra ? rnd() : a;
      f1[i] = rb ? rnd() : b;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_busy", busy, 0);
    chk("rst_done", calib_done, 0);
    chk("rst_off", offset_o[31:0], 0);
    chk("rst_cvld", corr_vld, 0);
    mon_en = 1;

    // Constant mean
    fill(100, -5, 0, 0);
    tick(0, 0, 0, 1, 2'b11);
    frames(0, -1);
    chk("s1_busy_div", busy, 1);
    idle(1);
    chk("s1_busy_end", busy, 0);
    chk("s1_off0", sx(offset_o[15:0]), 100);
    chk("s1_off1", sx(offset_o[31:16]), -5);
    chk("s1_done", calib_done, 3);
    tick(1, 100, -5, 0, 2'b11);
    chk("s1_corr0", sx(corr_o[15:0]), 0);
    chk("s1_corr1", sx(corr_o[31:16]), 0);

    // Rounding toward -inf
    fill(0, 0, 0, 1);
    f0 = '{7, 7, -1, -2, -1, -2, -1, -2, -1, -2};
    tick(0, 0, 0, 1, 2'b11);
    frames(0, -1);
    idle(1);
    chk("rnd_off0", sx(offset_o[15:0]), -2);
    chk("rnd_off1", sx(offset_o[31:16]), mean(1));

    // Saturation both directions
    fill(-100, 0, 0, 0);
    tick(0, 0, 0, 1, 2'b01);
    frames(0, -1);
    idle(1);
    tick(1, 32767, 0, 0, 2'b01);
    chk("sat_hi", sx(corr_o[15:0]), 32767);
    fill(100, 0, 0, 0);
    tick(0, 0, 0, 1, 2'b01);
    frames(0, -1);
    idle(1);
    tick(1, -32768, 0, 0, 2'b01);
    chk("sat_lo", sx(corr_o[15:0]), -32768);

    // Mask: recalibrate ch1 only
    fill(0, 0, 1, 1);
    tick(0, 0, 0, 1, 2'b11);
    frames(0, -1);
    idle(1);
    sv0 = sx(offset_o[15:0]);
    chk("msk_full0", sv0, mean(0));
    fill(0, 7, 1, 0);
    tick(0, 0, 0, 1, 2'b10);
    chk("msk_done1_drop", calib_done[1], 0);
    chk("msk_done0_keep", calib_done[0], 1);
    frames(0, -1);
    idle(1);
    chk("msk_off0_keep", sx(offset_o[15:0]), sv0);
    chk("msk_off1", sx(offset_o[31:16]), 7);
    chk("msk_done", calib_done, 3);
    tick(0, 0, 0, 1, 2'b00);
    chk("msk0_busy", busy, 0);

    // Reset mid-ACC, then a fresh calibration
    fill(0, 0, 1, 1);
    tick(0, 0, 0, 1, 2'b11);
    for (int i = 0; i < SETTLE + 4; i++) tick(1, f0[i], f1[i], 0, 2'b11);
    rst = 1; #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_done", calib_done, 0);
    chk("mrst_off", offset_o[31:0], 0);
    @(posedge clk); #1 rst = 0;
    fill(0, 0, 1, 1);
    tick(0, 0, 0, 1, 2'b11);
    frames(0, -1);
    idle(1);
    chk("mrst_new0", sx(offset_o[15:0]), mean(0));
    chk("mrst_new1", sx(offset_o[31:16]), mean(1));

    // Back-to-back strobes, request during ACC, strobe during DIV
    fill(0, 0, 1, 1);
    sv0 = sx(offset_o[15:0]);
    sv1 = sx(offset_o[31:16]);
    tick(0, 0, 0, 1, 2'b11);
    frames(1, 5);
    tick(1, 32767, 32767, 0, 2'b11);
    chk("b2b_div_corr0", sx(corr_o[15:0]), sat(32767 - sv0));
    chk("b2b_busy", busy, 0);
    chk("b2b_off0", sx(offset_o[15:0]), mean(0));
    chk("b2b_off1", sx(offset_o[31:16]), mean(1));
    idle(2);
    chk("b2b_noqueue", busy, 0);

    // Random traffic
    for (int i = 0; i < 600; i++)
      tick($urandom_range(0, 1), rnd(), rnd(), $urandom_range(0, 7) == 0,
           2'($urandom_range(0, 3)));
    idle(30);
    sdone = 0;
    for (int c = 0; c < CH; c++) sdone |= int'(m_done[c]) << c;
    chk("rand_done", calib_done, sdone);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/audio_calib_ctrl.md
# audio_calib_ctrl

Parametrised multi-channel DC-offset calibration controller for the ANC audio front end. On request it discards a settling window of sample frames, averages 2^LOG2N frames per enabled channel and latches a per-channel offset. It then streams offset-corrected, saturated samples to the filter datapath. It generalises the fixed two-flag calibration outputs of the boot block to CH channels with per-channel enable, done flags and correction.

## Interface
Parameters:
- CH, 4, number of audio channels
- DW, 16, signed sample width
- LOG2N, 8, log2 of frames averaged per calibration
- SETTLE, 16, frames discarded before accumulation (0 allowed)

Ports:
- clk  in  1  system clock; one clock, all logic on rising edge
- rst_n  in  1  reset; asynchronous and active-high (asserted = 1, despite suffix)
- sample_i  in  CH*DW  channel c in bits [c*DW +: DW], signed two's complement
- sample_vld  in  1  one-cycle strobe, one frame (all channels)
- calib_req  in  1  start request, level or pulse
- ch_mask  in  CH  channels to calibrate; sampled when request is accepted
- busy  out  1  calibration in progress
- calib_done  out  CH  per-channel calibrated flag
- offset_o  out  CH*DW  latched offset per channel
- corr_o  out  CH*DW  sample_i minus offset_o, saturated to DW
- corr_vld  out  1  corr_o valid strobe

## Operation
- Reset: all outputs 0, offsets 0, accumulators 0, FSM IDLE, counters 0.
- FSM states: IDLE, SETTLE, ACC, DIV.
- IDLE: calib_req=1 and ch_mask!=0 -> capture mask, clear calib_done bits of masked channels, clear accumulators and counters, go SETTLE (or ACC if SETTLE=0). With ch_mask=0, the request is ignored.
- SETTLE: count sample_vld frames. On the SETTLE-th frame -> ACC. That frame is not accumulated.
- ACC: on each sample_vld, acc[c] += sign-extended sample for masked channels. Accumulator width is DW+LOG2N signed, so overflow is impossible. On the 2^LOG2N-th frame -> DIV.
- DIV (one cycle): offset[c] = acc[c] >>> LOG2N for masked channels. This is an arithmetic shift, so it rounds toward −inf. Set calib_done[c] for masked channels. Go IDLE.
- Unmasked channels keep their offset_o and calib_done unchanged throughout.
- calib_req while busy: ignored, no queuing.
- sample_vld in DIV: not accumulated. It is corrected with the old offset.
- Correction runs in every state:
  - diff = sample − offset, computed at DW+1 bits.
  - diff > 2^(DW−1)−1 saturates to the maximum; diff < −2^(DW−1) saturates to the minimum.
  - Channels never calibrated have offset 0 and pass through unchanged.
- Reset asserted mid-operation: immediate return to the reset state. Partial accumulation is lost and no offset is updated.

## Timing
- Correction latency: corr_vld and corr_o are registered 1 cycle after sample_vld. corr_vld is a 1-cycle pulse.
- Request accepted in cycle t: busy=1 from t+1. Masked calib_done bits are 0 from t+1.
- Last ACC frame strobe in cycle u: DIV in u+1. From u+2: offset_o updated, calib_done set, busy=0.
- The sample_vld at u+1 is corrected with the old offset. Strobes at u+2 or later use the new offset.
- A new request is accepted at u+2 at the earliest.
- Total calibration: SETTLE + 2^LOG2N frames, plus 2 cycles.
- sample_vld spacing is arbitrary, including back-to-back every cycle.

## Test plan
Every scenario uses CH=2, DW=16, LOG2N=3, SETTLE=2.
- Constant mean: ch0=100, ch1=−5, mask=2'b11, 10 frames. Required:
  - offset_o = {−5, 100}, calib_done = 2'b11.
  - busy falls exactly 2 cycles after the 10th strobe.
  - Subsequent corr_o = {0, 0}.
- Rounding: ch0 alternates −1/−2 after the settle frames. Sum −12 gives offset −2 (floor), not −1.
- Saturation:
  - With offset ch0 = −100, input 32767 gives corr 32767.
  - With offset ch0 = 100, input −32768 gives corr −32768.
- Mask: after full calibration, request with mask=2'b10 and ch1=7. Required:
  - ch0 offset and calib_done[0] are unchanged.
  - calib_done[1] drops on acceptance and rises with offset 7.
  - mask=0 request leaves busy=0.
- Reset mid-ACC: assert rst_n=1 after 4 ACC frames. Outputs return to 0 asynchronously. A fresh request then completes with the correct mean.
- Request while busy plus back-to-back strobes: pulse calib_req during ACC with sample_vld every cycle. Required:
  - The extra request is ignored.
  - Frame counts are exact.
  - A strobe during DIV is not accumulated.
